ui_param_loader: RTL and testbench

//  Consumer side of the UI change trigger. Waits for the switches to stop moving after a trigger,

---
 rtl/ui_param_loader.sv | 164 ++++++++++++++++
 tb/tb_ui_param_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ui_param_loader.sv
// ui_param_loader: waits for UI switches to settle after a change trigger,
// snapshots them and streams each FIELD_W-bit field to the core's parameter
// bank as a valid/ready write beat (addr = field index, data = field value).
// Optional build macro UI_PARAM_DIFF_EN: only fields that differ from the last
// accepted value are sent, tracked in a per-field shadow register.
module ui_param_loader #(
  parameter int SETTLE_CYCLES = 100000,
  parameter int NUM_FIELDS    = 4,
  parameter int FIELD_W       = 4,
  localparam int AW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int CW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_FIELDS*FIELD_W-1:0] sw_in,
  input  logic                          update_trig_in,
  output logic                          param_valid_out,
  input  logic                          param_ready_in,
  output logic [AW-1:0]                 param_addr_out,
  output logic [FIELD_W-1:0]            param_data_out,
  output logic                          busy_out
);

  typedef enum logic [1:0] {IDLE, SETTLE, SEND} state_e;

  state_e                              state_q;
  logic [CW-1:0]                       cnt_q;
  logic [NUM_FIELDS-1:0][FIELD_W-1:0]  snap_q;
  logic [NUM_FIELDS-1:0][FIELD_W-1:0]  sw_f;
  logic [AW-1:0]                       idx_q;
  logic                                pend_q;
  logic                                valid_q;
  logic                                busy_q;
  logic [AW-1:0]                       addr_q;
  logic [FIELD_W-1:0]                  data_q;
`ifdef UI_PARAM_DIFF_EN
  logic [NUM_FIELDS-1:0][FIELD_W-1:0]  shadow_q;
`endif

  // Fields to send: at capture (live switches) and during the burst (snapshot)
  logic [NUM_FIELDS-1:0] cap_mask, snap_mask;
  logic [AW-1:0]         first_idx, nxt_idx;
  logic                  cap_any, nxt_found;

  assign sw_f = sw_in;

  // Per-field send masks; without the diff feature every field is sent
  always_comb begin
    cap_mask  = '1;
    snap_mask = '1;
`ifdef UI_PARAM_DIFF_EN
    for (int i = 0; i < NUM_FIELDS; i++) begin
      cap_mask[i]  = (sw_f[i]   != shadow_q[i]);
      snap_mask[i] = (snap_q[i] != shadow_q[i]);
    end
`endif
  end

  // Lowest field to send at capture, and next field above the current index
  always_comb begin
    first_idx = '0;
    cap_any   = 1'b0;
    nxt_idx   = idx_q;
    nxt_found = 1'b0;
    for (int i = NUM_FIELDS-1; i >= 0; i--) begin
      if (cap_mask[i]) begin
        first_idx = AW'(i);
        cap_any   = 1'b1;
      end
    end
    for (int i = NUM_FIELDS-1; i >= 0; i--) begin
      if (snap_mask[i] && (i > int'(idx_q))) begin
        nxt_idx   = AW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; the first SEND cycle loads the beat
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      snap_q   <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
`ifdef UI_PARAM_DIFF_EN
      shadow_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (update_trig_in) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (update_trig_in) begin
            cnt_q <= '0;                       // debounce restart
          end else if (cnt_q == CW'(SETTLE_CYCLES-1)) begin
            cnt_q  <= '0;
            snap_q <= sw_f;
            idx_q  <= first_idx;
            if (cap_any) begin
              state_q <= SEND;
            end else begin
              state_q <= IDLE;                 // nothing changed, no beats
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SEND: begin
          if (update_trig_in) pend_q <= 1'b1;
          if (!valid_q) begin
            valid_q <= 1'b1;
            addr_q  <= idx_q;
            data_q  <= snap_q[idx_q];
          end else if (param_ready_in) begin
`ifdef UI_PARAM_DIFF_EN
            shadow_q[idx_q] <= snap_q[idx_q];
`endif
            if (nxt_found) begin
              idx_q  <= nxt_idx;
              addr_q <= nxt_idx;
              data_q <= snap_q[nxt_idx];
            end else begin
              valid_q <= 1'b0;
              addr_q  <= '0;
              data_q  <= '0;
              idx_q   <= '0;
              pend_q  <= 1'b0;
              if (pend_q || update_trig_in) begin
                state_q <= SETTLE;
                cnt_q   <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign param_valid_out = valid_q;
  assign param_addr_out  = addr_q;
  assign param_data_out  = data_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_ui_param_loader.sv
// Scoreboard bench for ui_param_loader: each load pushes its expected beats
// (derived from the switch value and a per-field last-sent table), and a
// negedge monitor pops and compares on every accepted beat.
module tb_ui_param_loader;
  localparam int S = 4, NF = 4, FW = 4;

  logic          clk = 1'b0, rst_n = 1'b0, trig = 1'b0, ready = 1'b0;
  logic [NF*FW-1:0] sw = '0;
  logic          vld, busy;
  logic [1:0]    addr;
  logic [FW-1:0] data;

  int checks = 0, failures = 0, cyc = 0, exp_first = -1, acc_cnt = 0;
  bit rand_ready = 1'b0;

  typedef struct packed { logic [1:0] a; logic [FW-1:0] d; } beat_t;
  beat_t         exp_q[$];
  logic [FW-1:0] mdl_shadow [NF];
  logic          pv = 1'b0;
  logic [1:0]    pa = '0;
  logic [FW-1:0] pd = '0;

  ui_param_loader #(.SETTLE_CYCLES(S), .NUM_FIELDS(NF), .FIELD_W(FW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .sw_in(sw), .update_trig_in(trig),
    .param_valid_out(vld), .param_ready_in(ready), .param_addr_out(addr),
    .param_data_out(data), .busy_out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sampled on the negedge: stability of stalled beats, latency, scoreboard
  task automatic monitor_step();
    beat_t e;
    if (!rst_n) begin
      pv = 1'b0;
      return;
    end
    if (pv) begin
      chk("hold_valid", 32'(vld), 1);
      chk("hold_addr", 32'(addr), 32'(pa));
      chk("hold_data", 32'(data), 32'(pd));
    end
    if (vld && exp_first >= 0) begin
      chk("first_beat_cycle", cyc, exp_first);
      exp_first = -1;
    end
    if (vld && ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected: got addr %0d data %0h, expected no beat", addr, data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_addr", 32'(addr), 32'(e.a));
        chk("beat_data", 32'(data), 32'(e.d));
      end
    end
    pv = vld && !ready;
    pa = addr;
    pd = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic trig_pulse();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  // Reference: which fields a load of 'val' must deliver, in ascending order
  task automatic push_load(input logic [NF*FW-1:0] val);
    logic [FW-1:0] f;
    for (int i = 0; i < NF; i++) begin
      f = val[i*FW +: FW];
`ifdef UI_PARAM_DIFF_EN
      if (f != mdl_shadow[i]) begin
        exp_q.push_back({2'(i), f});
        mdl_shadow[i] = f;
      end
`else
      exp_q.push_back({2'(i), f});
`endif
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      if (!busy && !vld) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 1);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (vld) seen = 1'b1;
    end
    chk("valid_seen", 32'(seen), 1);
  endtask

  initial begin
    int t0, a0, ntrig, gap;
    logic [NF*FW-1:0] v;
    bit seen;
    for (int i = 0; i < NF; i++) mdl_shadow[i] = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // reset state
    #1;
    chk("rst_valid", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single trigger, back-to-back beats, busy drops after last beat
    ready = 1'b1;
    sw = 16'hA5C3;
    push_load(sw);
    a0 = acc_cnt;
    trig_pulse();
    exp_first = cyc + 5;
    wait_valid(12);
    repeat (4) tick();
    chk("t1_valid_after_burst", 32'(vld), 0);
    chk("t1_busy_after_burst", 32'(busy), 0);
    chk("t1_beats", acc_cnt - a0, 4);

    // 2: retriggers restart settling; snapshot taken at capture, not at trigger
    sw = 16'h0000;
    trig_pulse();
    t0 = cyc;
    tick();
    trig_pulse();
    tick();
    trig_pulse();
    tick();
    sw = 16'h1234;
    push_load(sw);
    exp_first = t0 + 9;
    wait_idle(40);

    // 3: beat 1 stalled for six cycles
    sw = 16'h5A69;
    push_load(sw);
    ready = 1'b0;
    trig_pulse();
    wait_valid(12);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (6) begin
      tick();
      chk("t3_stall_valid", 32'(vld), 1);
      chk("t3_stall_addr", 32'(addr), 1);
    end
    ready = 1'b1;
    wait_idle(40);

    // 4: trigger during beat 2 queues a second burst
    sw = 16'h8421;
    push_load(sw);
    a0 = acc_cnt;
    trig_pulse();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (vld && addr == 2'd2) seen = 1'b1;
    end
    chk("t4_beat2_seen", 32'(seen), 1);
    sw = 16'hFFFF;
    trig_pulse();
    push_load(sw);
    wait_idle(60);
    chk("t4_beats", acc_cnt - a0, 8);

    // 5: reset mid-burst
    sw = 16'h3C3C;
    push_load(sw);
    trig_pulse();
    wait_valid(12);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(vld), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_addr", 32'(addr), 0);
    chk("t5_data", 32'(data), 0);
    exp_q.delete();
    for (int i = 0; i < NF; i++) mdl_shadow[i] = '0;
    tick();
    rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (8) tick();
    chk("t5_idle_valid", 32'(vld), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_no_beats", acc_cnt - a0, 0);

`ifdef UI_PARAM_DIFF_EN
    // 6: only changed fields are sent
    sw = 16'h1234;
    push_load(sw);
    trig_pulse();
    wait_idle(40);
    sw = 16'h1294;
    push_load(sw);
    a0 = acc_cnt;
    trig_pulse();
    wait_idle(40);
    chk("t6_single_beat", acc_cnt - a0, 1);
    push_load(sw);
    a0 = acc_cnt;
    trig_pulse();
    wait_idle(40);
    chk("t6_no_beats", acc_cnt - a0, 0);
`endif

    // randomized loads with random backpressure and retriggers within settling
    rand_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      v = sw;
      if ($urandom_range(0, 1) == 0) v = 16'($urandom());
      else v[$urandom_range(0, NF-1)*FW +: FW] = 4'($urandom());
      sw = v;
      push_load(sw);
      ntrig = $urandom_range(1, 3);
      for (int k = 0; k < ntrig; k++) begin
        trig_pulse();
        if (k != ntrig-1) begin
          gap = $urandom_range(0, 3);
          repeat (gap) tick();
        end
      end
      wait_idle(300);
    end
    rand_ready = 1'b0;
    ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
